// File: rtl/trace_pkg.sv
// Shared trace entry record and kind codes for the writeback trace FIFO.
// One entry: kind, pc, addr, data (97 bits).
package trace_pkg;

  localparam logic KIND_GRF = 1'b0;
  localparam logic KIND_DM  = 1'b1;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_t;

endpackage

// File: rtl/trace_ram.sv
// Trace entry storage: DEPTH x 97, two write ports, async read.
// Port 0 holds the older entry when both ports write together.
module trace_ram
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we0,
  input  logic [AW-1:0] waddr0,
  input  trace_t        wdata0,
  input  logic          we1,
  input  logic [AW-1:0] waddr1,
  input  trace_t        wdata1,
  input  logic [AW-1:0] raddr,
  output trace_t        rdata
);

  trace_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_fifo.sv
// Writeback trace FIFO: captures GRF/DM write events, up to two per cycle.
// Define WB_TRACE_DROP_COUNT_EN to add the saturating drop_count output.
module wb_trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             grf_we,
  input  logic [31:0]      grf_pc,
  input  logic [4:0]       grf_addr,
  input  logic [31:0]      grf_data,
  input  logic             dm_we,
  input  logic [31:0]      dm_pc,
  input  logic [31:0]      dm_addr,
  input  logic [31:0]      dm_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_kind,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_addr,
  output logic [31:0]      out_data,
  output logic             overflow
`ifdef WB_TRACE_DROP_COUNT_EN
  ,
  output logic [CNT_W-1:0] drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          armed;

  logic          grf_ev;
  logic          dm_ev;
  logic          pop;
  logic [AW:0]   free;
  logic [1:0]    n_ev;
  logic [1:0]    n_push;
  logic [1:0]    n_drop;
  trace_t        grf_ent;
  trace_t        dm_ent;
  trace_t        ent0;
  trace_t        head;

  assign grf_ent = '{kind: KIND_GRF, pc: grf_pc,
                     addr: {27'd0, grf_addr}, data: grf_data};
  assign dm_ent  = '{kind: KIND_DM, pc: dm_pc,
                     addr: dm_addr, data: dm_data};

  assign out_valid = (count != '0);

  always_comb begin
    // armed masks the first edge after reset release
    grf_ev = armed && grf_we && (grf_addr != 5'd0);
    dm_ev  = armed && dm_we;
    pop    = out_valid && out_ready;
    free   = FULL - count + {{AW{1'b0}}, pop};
    n_ev   = {1'b0, grf_ev} + {1'b0, dm_ev};
    if ({{(AW-1){1'b0}}, n_ev} <= free) n_push = n_ev;
    else n_push = free[1:0];
    n_drop = n_ev - n_push;
    ent0   = grf_ev ? grf_ent : dm_ent;
  end

  trace_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk    (clk),
    .we0    (n_push != 2'd0),
    .waddr0 (wptr),
    .wdata0 (ent0),
    .we1    (n_push == 2'd2),
    .waddr1 (wptr + AW'(1)),
    .wdata1 (dm_ent),
    .raddr  (rptr),
    .rdata  (head)
  );

  always_comb begin
    {out_kind, out_pc, out_addr, out_data} = '0;
    if (out_valid) {out_kind, out_pc, out_addr, out_data} = head;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      armed    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      armed    <= 1'b1;
      wptr     <= wptr + AW'(n_push);
      rptr     <= rptr + AW'(pop);
      count    <= count + {{(AW-1){1'b0}}, n_push}
                        - {{AW{1'b0}}, pop};
      overflow <= overflow | (n_drop != 2'd0);
    end
  end

`ifdef WB_TRACE_DROP_COUNT_EN
  logic [CNT_W:0] dsum;

  assign dsum = {1'b0, drop_count} + (CNT_W+1)'(n_drop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_count <= '0;
    else drop_count <= dsum[CNT_W] ? '1 : dsum[CNT_W-1:0];
  end
`endif

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Scoreboard bench for wb_trace_fifo: queue-based reference model,
// directed corner cases then randomized traffic.
module tb_wb_trace_fifo;
  import trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic        clk;
  logic        reset;
  logic        grf_we;
  logic [31:0] grf_pc;
  logic [4:0]  grf_addr;
  logic [31:0] grf_data;
  logic        dm_we;
  logic [31:0] dm_pc;
  logic [31:0] dm_addr;
  logic [31:0] dm_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_kind;
  logic [31:0] out_pc;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic        overflow;
`ifdef WB_TRACE_DROP_COUNT_EN
  logic [CNT_W-1:0] drop_count;
`endif

  wb_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .grf_we    (grf_we),
    .grf_pc    (grf_pc),
    .grf_addr  (grf_addr),
    .grf_data  (grf_data),
    .dm_we     (dm_we),
    .dm_pc     (dm_pc),
    .dm_addr   (dm_addr),
    .dm_data   (dm_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_kind  (out_kind),
    .out_pc    (out_pc),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .overflow  (overflow)
`ifdef WB_TRACE_DROP_COUNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pops = 0;
  trace_t exp_q[$];
  int model_occ = 0;
  bit model_ovf = 1'b0;
  longint model_drops = 0;
  bit just_rel = 1'b0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // monitor: compare the presented head against the scoreboard
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_entry actual=valid required=empty");
      end else begin
        chk("out_kind", out_kind, exp_q[0].kind);
        chk("out_pc", out_pc, exp_q[0].pc);
        chk("out_addr", out_addr, exp_q[0].addr);
        chk("out_data", out_data, exp_q[0].data);
        if (out_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end else begin
      chk("idle_zero", {out_kind, out_pc, out_addr, out_data}, '0);
    end
  end

  task automatic step(bit gwe, logic [4:0] ga, logic [31:0] gpc,
                      logic [31:0] gd, bit dwe, logic [31:0] dpc,
                      logic [31:0] da, logic [31:0] dd, bit rdy);
    trace_t ev[$];
    int popn;
    int free;
    int acc;
    int drops;
    grf_we = gwe; grf_addr = ga; grf_pc = gpc; grf_data = gd;
    dm_we = dwe; dm_pc = dpc; dm_addr = da; dm_data = dd;
    out_ready = rdy;
    popn = (model_occ > 0 && rdy) ? 1 : 0;
    if (gwe && ga != 5'd0)
      ev.push_back('{kind: KIND_GRF, pc: gpc, addr: {27'd0, ga}, data: gd});
    if (dwe)
      ev.push_back('{kind: KIND_DM, pc: dpc, addr: da, data: dd});
    if (just_rel) ev.delete();
    free = DEPTH - model_occ + popn;
    acc = (ev.size() < free) ? ev.size() : free;
    for (int i = 0; i < acc; i++) exp_q.push_back(ev[i]);
    drops = ev.size() - acc;
    if (drops > 0) model_ovf = 1'b1;
    model_drops = model_drops + drops;
    if (model_drops > (64'd1 << CNT_W) - 1) model_drops = (64'd1 << CNT_W) - 1;
    model_occ = model_occ + acc - popn;
    just_rel = 1'b0;
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, model_occ > 0);
    chk("overflow", overflow, model_ovf);
`ifdef WB_TRACE_DROP_COUNT_EN
    chk("drop_count", drop_count, model_drops);
`endif
  endtask

  task automatic idle(bit rdy);
    step(0, 5'd0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic one_event(int i, bit rdy);
    if (i % 2 == 0)
      step(1, 5'(1 + i % 31), 32'h4000 + 32'(i * 4), $urandom, 0, 0, 0, 0, rdy);
    else
      step(0, 5'd0, 0, 0, 1, 32'h5000 + 32'(i * 4), $urandom, $urandom, rdy);
  endtask

  task automatic do_reset_assert();
    reset = 1'b0;
    grf_we = 0; dm_we = 0; out_ready = 0;
    exp_q.delete();
    model_occ = 0;
    model_ovf = 1'b0;
    model_drops = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset_assert();
    grf_pc = 0; grf_addr = 0; grf_data = 0;
    dm_pc = 0; dm_addr = 0; dm_data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_fields", {out_kind, out_pc, out_addr, out_data}, '0);
    #2 reset = 1'b1;
    just_rel = 1'b1;
    step(1, 5'd7, 32'h2000, 32'hDEAD, 1, 32'h2004, 32'h8, 32'h1, 1);
    idle(1);

    step(1, 5'd5, 32'h3000, 32'h1234, 0, 0, 0, 0, 0);
    chk("grf_kind", out_kind, KIND_GRF);
    chk("grf_addr", out_addr, 32'd5);
    chk("grf_data", out_data, 32'h1234);
    chk("grf_pc", out_pc, 32'h3000);
    idle(0);
    idle(1);
    idle(1);

    step(1, 5'd0, 32'h3010, 32'h77, 0, 0, 0, 0, 1);

    step(1, 5'd3, 32'h3004, 32'hAA, 1, 32'h3008, 32'h10, 32'hFF, 0);
    pops = 0;
    idle(1);
    idle(1);
    chk("dual_pops", pops, 2);
    idle(1);

    for (int i = 0; i < 15; i++) one_event(i, 0);
    step(1, 5'd9, 32'h6000, 32'h99, 1, 32'h6004, 32'h20, 32'h55, 0);
    chk("ovf_set", overflow, 1'b1);
`ifdef WB_TRACE_DROP_COUNT_EN
    chk("drop_one", drop_count, 1);
`endif
    pops = 0;
    repeat (20) idle(1);
    chk("drain16", pops, 16);

    for (int i = 0; i < 16; i++) one_event(i, 0);
    pops = 0;
    step(0, 5'd0, 0, 0, 1, 32'h7000, 32'h40, 32'h1111, 1);
    repeat (20) idle(1);
    chk("full_push_pop", pops, 17);

    for (int i = 0; i < 8; i++) one_event(i, 0);
    #2 do_reset_assert();
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_overflow", overflow, 1'b0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    just_rel = 1'b1;
    step(1, 5'd4, 32'h8000, 32'h4, 0, 0, 0, 0, 1);
    repeat (3) idle(1);

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
           $urandom, $urandom_range(0, 1), $urandom, $urandom, $urandom,
           $urandom_range(0, 3) != 0);
    end
    repeat (40) idle(1);
    chk("final_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
